// File: rtl/rvfi_commit_serializer.sv
// Serialises NR_COMMIT_PORTS RVFI commit records per cycle into one in-order
// record per cycle through a FIFO; whole commit cycles are dropped on overflow.
module rvfi_commit_serializer #(
  parameter  int unsigned NR_COMMIT_PORTS = 2,
  parameter  int unsigned REC_W           = 168,
  parameter  int unsigned DEPTH           = 8,
  localparam int unsigned PORT_W = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1,
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1),
  localparam int unsigned CNT_W  = $clog2(NR_COMMIT_PORTS + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             enable_i,
  input  logic                             flush_i,
  input  logic [NR_COMMIT_PORTS-1:0]       commit_valid_i,
  input  logic [NR_COMMIT_PORTS*REC_W-1:0] commit_data_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [REC_W-1:0]                 out_data_o,
  output logic [PORT_W-1:0]                out_port_o,
  output logic [31:0]                      out_seq_o,
  output logic                             overflow_o,
  output logic [31:0]                      drop_cnt_o,
  output logic [LVL_W-1:0]                 level_o
);

  typedef struct packed {
    logic [PORT_W-1:0] port;
    logic [REC_W-1:0]  data;
  } entry_t;

  entry_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [31:0]      seq_q, seq_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0]   n_in;
  logic [PTR_W-1:0]   port_addr [NR_COMMIT_PORTS];
  logic               port_we   [NR_COMMIT_PORTS];
  logic               pop;
  logic               accept;
  logic               push_en;
  logic [LVL_W:0]     free;
  logic [32:0]        drop_sum;

  // Compaction: each valid port lands at wr_ptr plus the count of older valid ports.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    n_in = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      port_we[i]   = 1'b0;
      port_addr[i] = '0;
      if (enable_i && commit_valid_i[i]) begin
        port_we[i]   = 1'b1;
        port_addr[i] = wr_ptr_q + PTR_W'(n_in);
        n_in         = n_in + 1'b1;
      end
    end
  end

  always_comb begin
    pop      = (level_q != '0) && out_ready_i;
    free     = (LVL_W+1)'(DEPTH) - {1'b0, level_q} + (LVL_W+1)'(pop);
    accept   = (LVL_W+1)'(n_in) <= free;
    push_en  = accept && !flush_i;
    drop_sum = {1'b0, drop_cnt_q} + 33'(n_in);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    seq_d      = seq_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        seq_d    = seq_q + 32'd1;
      end
      if (accept) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(n_in);
        level_d  = level_q + LVL_W'(n_in) - LVL_W'(pop);
      end else begin
        level_d    = level_q - LVL_W'(pop);
        overflow_d = 1'b1;
        drop_cnt_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: storage has no reset; level_q alone decides which slots are meaningful.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      if (push_en && port_we[i]) begin
        mem[port_addr[i]] <= '{port: PORT_W'(i), data: commit_data_i[i*REC_W +: REC_W]};
      end
    end
  end

  assign out_valid_o = (level_q != '0);
  assign out_data_o  = mem[rd_ptr_q].data;
  assign out_port_o  = mem[rd_ptr_q].port;
  assign out_seq_o   = seq_q;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;
  assign level_o     = level_q;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Random and directed stimulus against a queue-based reference model of the
// commit serializer: whole-cycle accept/reject, in-order drain, flush and reset.
module tb_rvfi_commit_serializer;

  localparam int NR     = 2;
  localparam int REC_W  = 168;
  localparam int DEPTH  = 8;
  localparam int PORT_W = 1;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  typedef struct {
    int              port;
    logic [REC_W-1:0] data;
  } rec_t;

  logic                    clk = 1'b0;
  logic                    rst_i;
  logic                    enable_i;
  logic                    flush_i;
  logic [NR-1:0]           commit_valid_i;
  logic [NR*REC_W-1:0]     commit_data_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [REC_W-1:0]        out_data_o;
  logic [PORT_W-1:0]       out_port_o;
  logic [31:0]             out_seq_o;
  logic                    overflow_o;
  logic [31:0]             drop_cnt_o;
  logic [LVL_W-1:0]        level_o;

  rvfi_commit_serializer #(
    .NR_COMMIT_PORTS(NR),
    .REC_W          (REC_W),
    .DEPTH          (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .flush_i        (flush_i),
    .commit_valid_i (commit_valid_i),
    .commit_data_i  (commit_data_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .out_port_o     (out_port_o),
    .out_seq_o      (out_seq_o),
    .overflow_o     (overflow_o),
    .drop_cnt_o     (drop_cnt_o),
    .level_o        (level_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  rec_t        q[$];
  logic [31:0] m_seq;
  logic        m_ovf;
  logic [31:0] m_drop;

  task automatic check(input string tag, input logic [REC_W-1:0] obs, input logic [REC_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] rand_rec();
    logic [REC_W-1:0] r = '0;
    for (int k = 0; k < 6; k++) r = (r << 32) | REC_W'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_seq  = '0;
    m_ovf  = 1'b0;
    m_drop = '0;
  endtask

  // One clock edge of the serializer's rules, applied to the queue model.
  task automatic model_step();
    int          n;
    int          free;
    bit          pop;
    logic [32:0] s;
    if (flush_i) begin
      q.delete();
      return;
    end
    n = 0;
    if (enable_i) for (int i = 0; i < NR; i++) if (commit_valid_i[i]) n++;
    pop  = (q.size() != 0) && out_ready_i;
    free = DEPTH - q.size() + (pop ? 1 : 0);
    if (pop) begin
      void'(q.pop_front());
      m_seq = m_seq + 32'd1;
    end
    if (n <= free) begin
      for (int i = 0; i < NR; i++)
        if (enable_i && commit_valid_i[i]) q.push_back('{port: i, data: commit_data_i[i*REC_W +: REC_W]});
    end else begin
      m_ovf  = 1'b1;
      s      = {1'b0, m_drop} + 33'(n);
      m_drop = s[32] ? 32'hFFFF_FFFF : s[31:0];
    end
  endtask

  task automatic check_all();
    check("valid", out_valid_o, q.size() != 0);
    check("level", level_o, q.size());
    check("seq", out_seq_o, m_seq);
    check("overflow", overflow_o, m_ovf);
    check("drop_cnt", drop_cnt_o, m_drop);
    if (q.size() != 0) begin
      check("data", out_data_o, q[0].data);
      check("port", out_port_o, q[0].port);
    end
  endtask

  // Called at a negedge: drive, take one posedge, update model, check at next negedge.
  task automatic cyc(input logic en, input logic fl, input logic rdy, input logic [NR-1:0] v);
    enable_i       = en;
    flush_i        = fl;
    out_ready_i    = rdy;
    commit_valid_i = v;
    for (int i = 0; i < NR; i++) commit_data_i[i*REC_W +: REC_W] = rand_rec();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic sync_reset();
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    model_reset();
    check_all();
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_i = 1'b1;
    #1;
    check({tag, "_valid"}, out_valid_o, 1'b0);
    check({tag, "_level"}, level_o, 0);
    model_reset();
    @(negedge clk);
    rst_i = 1'b0;
    check_all();
  endtask

  initial begin
    rst_i          = 1'b1;
    enable_i       = 1'b0;
    flush_i        = 1'b0;
    out_ready_i    = 1'b0;
    commit_valid_i = '0;
    commit_data_i  = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    check_all();

    // Single record, one-cycle latency, drains next cycle.
    repeat (3) cyc(1, 0, 1, 2'b00);
    cyc(1, 0, 1, 2'b01);
    check("t1_valid", out_valid_o, 1'b1);
    check("t1_seq", out_seq_o, 32'd0);
    cyc(1, 0, 1, 2'b00);
    check("t1_level", level_o, 0);

    // Two ports in one cycle, then port 1 alone.
    cyc(1, 0, 1, 2'b11);
    cyc(1, 0, 1, 2'b10);
    repeat (4) cyc(1, 0, 1, 2'b00);

    // Fill to DEPTH, reject a whole cycle, then drain.
    sync_reset();
    repeat (4) cyc(1, 0, 0, 2'b11);
    check("t3_full", level_o, DEPTH);
    cyc(1, 0, 0, 2'b11);
    check("t3_ovf", overflow_o, 1'b1);
    check("t3_drop", drop_cnt_o, 32'd2);
    check("t3_level", level_o, DEPTH);
    repeat (8) cyc(1, 0, 1, 2'b00);
    check("t3_seq", out_seq_o, 32'd8);

    // Same-cycle pop frees the slot needed for a two-record push.
    sync_reset();
    repeat (3) cyc(1, 0, 0, 2'b11);
    cyc(1, 0, 0, 2'b01);
    check("t4_level7", level_o, 7);
    cyc(1, 0, 1, 2'b11);
    check("t4_level8", level_o, DEPTH);
    check("t4_ovf", overflow_o, 1'b0);

    // Disabled capture ignores commits but keeps draining.
    repeat (4) cyc(0, 0, 1, 2'b11);
    check("en_level", level_o, 4);

    // Asynchronous reset with five records buffered.
    sync_reset();
    cyc(1, 0, 0, 2'b11);
    cyc(1, 0, 0, 2'b11);
    cyc(1, 0, 0, 2'b01);
    check("t6_level5", level_o, 5);
    async_reset_check("t6_rst");

    // Flush with three records buffered keeps seq and drop count.
    cyc(1, 0, 0, 2'b11);
    cyc(1, 0, 1, 2'b01);
    cyc(1, 0, 0, 2'b01);
    check("t6_level3", level_o, 3);
    cyc(1, 1, 1, 2'b11);
    check("t6_flush_level", level_o, 0);
    check("t6_flush_seq", out_seq_o, 32'd1);
    check("t6_flush_drop", drop_cnt_o, 32'd0);

    // Random traffic, wrapping pointers many times.
    for (int t = 0; t < 600; t++) begin
      if (t == 300) async_reset_check("rnd_rst");
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0,
          1'($urandom_range(0, 1)), NR'($urandom));
    end
    repeat (DEPTH + 2) cyc(1, 0, 1, 2'b00);
    check("final_empty", level_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvfi_commit_serializer.md
Name: rvfi_commit_serializer

Overview:
Sequences the multi-port RVFI commit stream into one in-order record per cycle for a single-port trace sink, such as the trace file writer or a DPI/UART trace channel. Sits between the core's RVFI output and the sink, so trace consumers need not handle NR_COMMIT_PORTS records per cycle. Buffers bursts in a FIFO and never stalls the core. On overflow it drops whole commit cycles and reports them.

Parameters:
NR_COMMIT_PORTS, 2, number of RVFI commit ports (1..4); lower index is older in program order
REC_W, 168, width of one packed commit record (pc, insn, mode, rd_addr, rd_wdata, trap flag)
DEPTH, 8, FIFO entries; power of two, >= NR_COMMIT_PORTS

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
enable_i  in  1  capture enable (trace window); commits are ignored when low
flush_i  in  1  synchronous FIFO clear
commit_valid_i  in  NR_COMMIT_PORTS  per-port record present (RVFI valid OR trap)
commit_data_i  in  NR_COMMIT_PORTS*REC_W  packed records; port i occupies bits [i*REC_W +: REC_W]
out_valid_o  out  1  head record available
out_ready_i  in  1  sink accepts the head record
out_data_o  out  REC_W  head record
out_port_o  out  max(1,$clog2(NR_COMMIT_PORTS))  source port of the head record
out_seq_o  out  32  sequence number of the head record
overflow_o  out  1  sticky; set on the first dropped cycle
drop_cnt_o  out  32  number of individual records dropped, saturating
level_o  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (rst_i high, asynchronous): rd/wr pointers = 0, occupancy = 0, out_valid_o = 0, out_seq_o = 0, overflow_o = 0, drop_cnt_o = 0. FIFO storage is not reset. out_data_o and out_port_o are don't-care while out_valid_o = 0.
- n_in is the popcount of commit_valid_i when enable_i = 1, else 0.
- pop = out_valid_o & out_ready_i. The head advances on the next edge. out_seq_o increments by 1 per pop and wraps modulo 2^32.
- Free space counts a same-cycle pop: free = DEPTH - level + pop.
- Accept the cycle if n_in <= free:
  - Write the valid ports in ascending index order to consecutive slots at wr_ptr, compacting out invalid ports.
  - Store each record together with its port index.
  - wr_ptr += n_in, modulo DEPTH.
- Reject the cycle if n_in > free:
  - Write none of the records. There is no partial write, so program order stays contiguous.
  - Set overflow_o.
  - drop_cnt_o += n_in, saturating at 32'hFFFF_FFFF.
  - Pointers and level are unchanged except for the pop.
- Latency: a record committed in cycle t appears at the FIFO head no earlier than t+1. There is no combinational bypass; an empty FIFO with a push in cycle t gives out_valid_o = 1 at t+1.
- level_next = level + (accepted ? n_in : 0) - pop. level_o is registered and never exceeds DEPTH. out_valid_o = (level != 0).
- Handshake: while out_valid_o & !out_ready_i, out_data_o, out_port_o and out_seq_o stay stable. out_valid_o never deasserts without a pop, except on flush_i or reset.
- flush_i (synchronous, highest priority after reset):
  - Pointers and level go to 0 on the next edge.
  - Commits in the same cycle are discarded and not counted as drops.
  - A same-cycle pop is ignored.
  - out_seq_o, overflow_o and drop_cnt_o are kept.
- Pointer wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. A multi-record push that straddles the end of storage wraps per record.
- Reset mid-burst: the FIFO empties immediately and out_valid_o = 0 asynchronously. Records in flight are lost and not counted.
- enable_i low: commits are ignored (not counted as drops). The FIFO keeps draining normally.

Test Plan:
1. Reset, enable_i = 1, out_ready_i = 1; port0 valid with record A at cycle 5 -> out_valid_o = 1 at cycle 6, out_data_o = A, out_port_o = 0, out_seq_o = 0; level_o returns to 0 at cycle 7.
2. Ports 0 and 1 valid in the same cycle (A on p0, B on p1); port 1 only (C) next cycle; out_ready_i = 1 -> output order A, B, C with seq 0, 1, 2 and ports 0, 1, 1; one pop per cycle.
3. out_ready_i = 0; push 2 records per cycle for 4 cycles -> level_o = 8. Fifth cycle (2 records) -> rejected, overflow_o = 1, drop_cnt_o = 2, level_o stays 8. Then set out_ready_i = 1 -> 8 in-order records, seq 0..7.
4. level = 7, one pop and 2 commits in the same cycle -> free = 2, cycle accepted, level_o = 8, overflow_o stays 0.
5. Run 20 records through DEPTH = 8 with random out_ready_i -> pointers wrap at least twice; the output sequence equals the input order with no gaps in seq.
6. Assert rst_i with level_o = 5 between clock edges -> out_valid_o = 0, level_o = 0 immediately. Assert flush_i with level_o = 3 -> level_o = 0 next edge, and out_seq_o and drop_cnt_o are unchanged.
